pixel_dispatcher: RTL and testbench
===================================

Name: pixel_dispatcher

Overview:
- Initiator side of the Mandelbrot iterator interface.
- Walks a raster frame pixel by pixel and computes the 4.23 fixed-point c = (cr, ci) for each pixel.
- For each pixel: resets and launches one iterator, waits for its done, then writes the escape count into the VGA pixel memory through a ready/valid write port.
- Sits between the top-level frame control (start/frame_done) and one iterator instance plus the video memory writer.

Parameters:
- H_PIXELS, 640, pixels per row.
- V_PIXELS, 480, rows per frame.
- ADDR_W, 19, width of the pixel address; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS.
- X_START, 27'h7000000, cr of column 0 (-2.0 in 4.23).
- Y_START, 27'h0800000, ci of row 0 (+1.0 in 4.23).
- DX, 27'd39322, cr increment per column (~3/640).
- DY, 27'd34953, ci decrement per row (~2/480).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from frame accept until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel write is accepted
- iter_reset  out  1  drives the iterator's reset
- cr  out  27  signed 4.23 real part to the iterator
- ci  out  27  signed 4.23 imaginary part to the iterator
- iter_counter  in  11  iterator escape count
- iter_done  in  1  iterator finished
- wr_en  out  1  pixel write valid
- wr_ready  in  1  memory accepts the write when high together with wr_en
- wr_addr  out  ADDR_W  linear pixel address, y*H_PIXELS + x
- wr_count  out  11  escape count to store

Behaviour:
- Reset values: busy=0, frame_done=0, iter_reset=1, wr_en=0, wr_addr=0, wr_count=0, cr=X_START, ci=Y_START, x=0, y=0, state=IDLE.
- Reset mid-frame aborts the frame immediately. No frame_done is issued.
- States:
  - IDLE: iter_reset=1. start moves to LAUNCH and sets busy=1. x, y, address and coordinates are cleared to 0/0/0/X_START/Y_START.
  - LAUNCH (exactly 1 cycle): iter_reset=1 with cr/ci already holding the current pixel's values. Goes to WAIT.
  - WAIT: iter_reset=0. iter_done is sampled only here. Because the iterator reset is synchronous, the stale done is cleared before the first WAIT cycle. On iter_done=1, latch wr_count <= iter_counter and go to WRITE.
  - WRITE: wr_en=1, with wr_addr/wr_count stable until the handshake. A transfer happens in a cycle with wr_en & wr_ready. wr_ready=0 stalls indefinitely with no data change. On transfer, go to ADVANCE.
  - ADVANCE (1 cycle):
    - Last pixel (x==H_PIXELS-1, y==V_PIXELS-1): pulse frame_done, clear busy, set iter_reset=1, go to IDLE.
    - End of row (x==H_PIXELS-1): x=0, cr=X_START, y+=1, ci-=DY, wr_addr+=1, go to LAUNCH.
    - Otherwise: x+=1, cr+=DX, wr_addr+=1, go to LAUNCH.
- cr/ci are only ever changed in ADVANCE/IDLE, so they are constant from LAUNCH through WRITE.
- Arithmetic: cr/ci are accumulated (no multiplier) with 27-bit two's-complement wrap and no saturation. The address is an incrementing counter (no multiplier).
- start while busy is ignored. start coincident with reset is ignored.
- Per-pixel latency = 1 (LAUNCH) + WAIT cycles (counter+1 for an in-range escape; 101 at the 100-iteration cap) + WRITE cycles (>=1) + 1 (ADVANCE).
- wr_ready is don't-care outside WRITE.

Decomposition:
- Shared package (mandel_pkg):
  - FIX_W=27, FRAC_W=23, COUNT_W=11, MAX_ITERATIONS=100.
  - Constants TWO, FOUR, NEGTWO.
  - Fixed-point literals for the default X_START/Y_START/DX/DY.
  - The state enum.
- One natural sub-module: pixel_walker. It holds the x/y counters, the cr/ci accumulators and wr_addr, with inputs clear and step, and outputs last_col and last_pixel. The FSM stays in pixel_dispatcher.

Test Plan:
- Bench uses H_PIXELS=4, V_PIXELS=2, a real iterator, and wr_ready tied to 1.
- First pixel: start -> iter_reset high for exactly 1 cycle; first write has wr_addr=0, cr=27'h7000000, ci=27'h0800000, wr_count=1 (zr<=-2 after one iteration).
- Interior point: X_START=0, Y_START=0, DX=0, DY=0 -> all 8 writes have wr_count=100; each pixel takes 104 cycles; wr_addr runs 0..7 in order; frame_done pulses once, 1 cycle after the address-7 transfer.
- Row wrap: at the write for address 4, cr=X_START and ci=Y_START-DY; at address 3, cr=X_START+3*DX.
- Backpressure: wr_ready held low 5 cycles in WRITE -> wr_en stays high, wr_addr/wr_count unchanged, no new LAUNCH; the transfer completes on the cycle wr_ready rises.
- Protocol edge cases:
  - start pulsed mid-frame -> ignored; exactly 8 writes occur.
  - reset asserted during WAIT -> next cycle busy=0, wr_en=0, iter_reset=1, no frame_done.
  - A fresh start after the abort restarts at wr_addr=0.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared fixed-point constants, default raster geometry and dispatcher states
// for the Mandelbrot renderer.
package mandel_pkg;

    localparam int FIX_W          = 27;
    localparam int FRAC_W         = 23;
    localparam int COUNT_W        = 11;
    localparam int MAX_ITERATIONS = 100;

    typedef logic signed [FIX_W-1:0] fix_t;

    // 4.23 literals: 1.0 == 2^23
    localparam fix_t TWO    = 27'sh1000000;
    localparam fix_t FOUR   = 27'sh2000000;
    localparam fix_t NEGTWO = 27'sh7000000;

    localparam fix_t DEF_X_START = NEGTWO;
    localparam fix_t DEF_Y_START = 27'sh0800000;
    localparam fix_t DEF_DX      = 27'sd39322;
    localparam fix_t DEF_DY      = 27'sd34953;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_ADVANCE
    } state_t;

endpackage

// File: rtl/pixel_walker.sv
// Raster position tracker: x/y counters, accumulated c = (cr, ci) and the
// linear pixel address, all advanced without multipliers.
module pixel_walker
    import mandel_pkg::*;
#(
    parameter int   H_PIXELS = 640,
    parameter int   V_PIXELS = 480,
    parameter int   ADDR_W   = 19,
    parameter fix_t X_START  = DEF_X_START,
    parameter fix_t Y_START  = DEF_Y_START,
    parameter fix_t DX       = DEF_DX,
    parameter fix_t DY       = DEF_DY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    step,
    output logic signed [FIX_W-1:0] cr,
    output logic signed [FIX_W-1:0] ci,
    output logic [ADDR_W-1:0]       addr,
    output logic                    last_col,
    output logic                    last_pixel
);

    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;

    assign last_col   = (x == XW'(H_PIXELS - 1));
    assign last_pixel = last_col && (y == YW'(V_PIXELS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
            cr   <= X_START;
            ci   <= Y_START;
        end else if (step) begin
            addr <= addr + ADDR_W'(1);
            // Row wrap rewinds cr and moves ci down one row; accumulators wrap freely
            if (last_col) begin
                x  <= '0;
                cr <= X_START;
                y  <= y + YW'(1);
                ci <= ci - DY;
            end else begin
                x  <= x + XW'(1);
                cr <= cr + DX;
            end
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Frame sequencer: launches one iterator per pixel, waits for its escape count
// and hands the result to the pixel memory over a ready/valid write port.
module pixel_dispatcher
    import mandel_pkg::*;
#(
    parameter int   H_PIXELS = 640,
    parameter int   V_PIXELS = 480,
    parameter int   ADDR_W   = 19,
    parameter fix_t X_START  = DEF_X_START,
    parameter fix_t Y_START  = DEF_Y_START,
    parameter fix_t DX       = DEF_DX,
    parameter fix_t DY       = DEF_DY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    iter_reset,
    output logic signed [FIX_W-1:0] cr,
    output logic signed [FIX_W-1:0] ci,
    input  logic [COUNT_W-1:0]      iter_counter,
    input  logic                    iter_done,
    output logic                    wr_en,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [COUNT_W-1:0]      wr_count
);

    state_t state;
    logic   clear;
    logic   step;
    logic   last_col;
    logic   last_pixel;
    logic   frame_end;

    assign frame_end = last_col && last_pixel;
    assign clear     = (state == S_IDLE) && start;
    assign step      = (state == S_ADVANCE) && !frame_end;

    pixel_walker #(
        .H_PIXELS (H_PIXELS),
        .V_PIXELS (V_PIXELS),
        .ADDR_W   (ADDR_W),
        .X_START  (X_START),
        .Y_START  (Y_START),
        .DX       (DX),
        .DY       (DY)
    ) u_walker (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .step       (step),
        .cr         (cr),
        .ci         (ci),
        .addr       (wr_addr),
        .last_col   (last_col),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            iter_reset <= 1'b1;
            wr_en      <= 1'b0;
            wr_count   <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    iter_reset <= 1'b1;
                    if (start) begin
                        busy  <= 1'b1;
                        state <= S_LAUNCH;
                    end
                end
                // iter_reset is high for this one cycle, clearing any stale done
                S_LAUNCH: begin
                    iter_reset <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (iter_done) begin
                        wr_count <= iter_counter;
                        wr_en    <= 1'b1;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    iter_reset <= 1'b1;
                    if (frame_end) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        state <= S_LAUNCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher on a 4x2 frame: default-coordinate instance (a)
// and an all-zero-coordinate instance (b), each with a behavioural iterator.
module tb_pixel_dispatcher;

    typedef struct {
        int          stall;
        logic [2:0]  addr;
        logic [26:0] cr;
        logic [26:0] ci;
        logic [10:0] count;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: default geometry constants
    logic        rst_a, start_a, busy_a, fd_a, ir_a, idone_a, wen_a, wrdy_a;
    logic [26:0] cr_a, ci_a;
    logic [10:0] icnt_a, wcnt_a;
    logic [2:0]  waddr_a;

    // Instance b: c = 0 everywhere, never escapes
    logic        rst_b, start_b, busy_b, fd_b, ir_b, idone_b, wen_b, wrdy_b;
    logic [26:0] cr_b, ci_b;
    logic [10:0] icnt_b, wcnt_b;
    logic [2:0]  waddr_b;

    pixel_dispatcher #(.H_PIXELS(4), .V_PIXELS(2), .ADDR_W(3)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .frame_done(fd_a),
        .iter_reset(ir_a), .cr(cr_a), .ci(ci_a), .iter_counter(icnt_a), .iter_done(idone_a),
        .wr_en(wen_a), .wr_ready(wrdy_a), .wr_addr(waddr_a), .wr_count(wcnt_a)
    );

    pixel_dispatcher #(.H_PIXELS(4), .V_PIXELS(2), .ADDR_W(3),
                       .X_START(27'sd0), .Y_START(27'sd0), .DX(27'sd0), .DY(27'sd0)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .frame_done(fd_b),
        .iter_reset(ir_b), .cr(cr_b), .ci(ci_b), .iter_counter(icnt_b), .iter_done(idone_b),
        .wr_en(wen_b), .wr_ready(wrdy_b), .wr_addr(waddr_b), .wr_count(wcnt_b)
    );

    // Behavioural iterator: z <- z^2 + c in 4.23, escape when |z|^2 > 4, cap at 100
    function automatic longint sx(input logic [26:0] v);
        return longint'(signed'(v));
    endfunction
    function automatic longint nzr(input longint zr, input longint zi, input longint c);
        return ((zr * zr - zi * zi) >>> 23) + c;
    endfunction
    function automatic longint nzi(input longint zr, input longint zi, input longint c);
        return ((2 * zr * zi) >>> 23) + c;
    endfunction
    function automatic bit esc(input longint zr, input longint zi);
        return (zr * zr + zi * zi) > (longint'(1) << 48);
    endfunction

    longint zra, zia, zrb, zib;
    always @(posedge clk) begin
        if (ir_a) begin
            zra <= 0; zia <= 0; icnt_a <= '0; idone_a <= 1'b0;
        end else if (!idone_a) begin
            zra     <= nzr(zra, zia, sx(cr_a));
            zia     <= nzi(zra, zia, sx(ci_a));
            icnt_a  <= icnt_a + 11'd1;
            idone_a <= esc(nzr(zra, zia, sx(cr_a)), nzi(zra, zia, sx(ci_a))) || (icnt_a == 11'd99);
        end
    end
    always @(posedge clk) begin
        if (ir_b) begin
            zrb <= 0; zib <= 0; icnt_b <= '0; idone_b <= 1'b0;
        end else if (!idone_b) begin
            zrb     <= nzr(zrb, zib, sx(cr_b));
            zib     <= nzi(zrb, zib, sx(ci_b));
            icnt_b  <= icnt_b + 11'd1;
            idone_b <= esc(nzr(zrb, zib, sx(cr_b)), nzi(zrb, zib, sx(ci_b))) || (icnt_b == 11'd99);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: expected writes are queued when a frame is started
    vec_t qa[$];
    vec_t qb[$];
    int nwr_a = 0, nfd_a = 0, nwr_b = 0, nfd_b = 0, last_b = 0;

    always @(negedge clk) begin
        vec_t e;
        if (wen_a && wrdy_a) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_unexpected_write: got addr %0d, expected no write", waddr_a);
            end else begin
                e = qa.pop_front();
                chk("a_addr", waddr_a, e.addr);
                chk("a_count", wcnt_a, e.count);
                chk("a_cr", cr_a, e.cr);
                chk("a_ci", ci_a, e.ci);
            end
            nwr_a++;
        end
        if (fd_a) nfd_a++;
        if (wen_b && wrdy_b) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected_write: got addr %0d, expected no write", waddr_b);
            end else begin
                e = qb.pop_front();
                chk("b_addr", waddr_b, e.addr);
                chk("b_count", wcnt_b, e.count);
                chk("b_cr", cr_b, e.cr);
                chk("b_ci", ci_b, e.ci);
            end
            if (nwr_b > 0) chk("b_pixel_cycles", cyc - last_b, 104);
            last_b = cyc;
            nwr_b++;
        end
        if (fd_b) begin
            nfd_b++;
            chk("b_done_delay", cyc - last_b, 2);
        end
    end

    vec_t tbl[8];

    task automatic run_frame_a(input int frames_before);
        bit got;
        foreach (tbl[i]) qa.push_back(tbl[i]);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        @(negedge clk);
        chk("a_launch_busy", busy_a, 1);
        chk("a_launch_iter_reset", ir_a, 1);
        @(negedge clk);
        chk("a_wait_iter_reset", ir_a, 0);
        for (int i = 0; i < 8; i++) begin
            wrdy_a = (tbl[i].stall == 0);
            got = 0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (wen_a) begin got = 1; break; end
            end
            if (!got) begin
                fail("a_write_timeout");
                return;
            end
            if (tbl[i].stall > 0) begin
                for (int k = 0; k < tbl[i].stall; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("a_stall_wr_en", wen_a, 1);
                    chk("a_stall_addr", waddr_a, tbl[i].addr);
                    chk("a_stall_count", wcnt_a, tbl[i].count);
                    chk("a_stall_no_launch", ir_a, 0);
                end
                @(posedge clk);
                #1 wrdy_a = 1'b1;
            end
            tick();
        end
        @(negedge clk);
        chk("a_advance_no_done", fd_a, 0);
        chk("a_advance_busy", busy_a, 1);
        @(negedge clk);
        chk("a_frame_done", fd_a, 1);
        chk("a_done_busy", busy_a, 0);
        chk("a_done_iter_reset", ir_a, 1);
        @(negedge clk);
        chk("a_done_one_cycle", fd_a, 0);
        chk("a_done_pulses", nfd_a, frames_before + 1);
        chk("a_queue_drained", qa.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 3'd0, 27'h7000000, 27'h0800000, 11'd1};
        tbl[1] = '{0, 3'd1, 27'h700999A, 27'h0800000, 11'd1};
        tbl[2] = '{5, 3'd2, 27'h7013334, 27'h0800000, 11'd1};
        tbl[3] = '{0, 3'd3, 27'h701CCCE, 27'h0800000, 11'd1};
        tbl[4] = '{0, 3'd4, 27'h7000000, 27'h07F7777, 11'd1};
        tbl[5] = '{0, 3'd5, 27'h700999A, 27'h07F7777, 11'd1};
        tbl[6] = '{2, 3'd6, 27'h7013334, 27'h07F7777, 11'd1};
        tbl[7] = '{0, 3'd7, 27'h701CCCE, 27'h07F7777, 11'd1};

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        wrdy_a = 1'b1; wrdy_b = 1'b1;
        repeat (3) tick();
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_frame_done", fd_a, 0);
        chk("rst_iter_reset", ir_a, 1);
        chk("rst_wr_en", wen_a, 0);
        chk("rst_wr_addr", waddr_a, 0);
        chk("rst_wr_count", wcnt_a, 0);
        chk("rst_cr", cr_a, 27'h7000000);
        chk("rst_ci", ci_a, 27'h0800000);
        chk("rst_b_busy", busy_b, 0);

        // start together with reset must not begin a frame
        tick();
        rst_a = 1'b1; start_a = 1'b1;
        tick();
        rst_a = 1'b0; start_a = 1'b0;
        @(negedge clk);
        chk("start_with_reset_busy", busy_a, 0);
        tick();

        run_frame_a(0);
        chk("a_writes_frame1", nwr_a, 8);

        // Abort during WAIT
        repeat (2) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        begin
            bit got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (busy_a && !ir_a && !wen_a) begin got = 1; break; end
            end
            if (!got) fail("a_reach_wait");
        end
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_a, 0);
        chk("abort_wr_en", wen_a, 0);
        chk("abort_iter_reset", ir_a, 1);
        repeat (20) tick();
        chk("abort_no_frame_done", nfd_a, 1);
        chk("abort_no_write", nwr_a, 8);

        run_frame_a(1);
        chk("a_writes_frame2", nwr_a, 16);

        // Interior frame with a start pulse dropped into the middle
        for (int p = 0; p < 8; p++) qb.push_back('{0, 3'(p), 27'h0, 27'h0, 11'd100});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (300) tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        begin
            bit got = 0;
            for (int k = 0; k < 3000; k++) begin
                @(negedge clk);
                if (nfd_b != 0) begin got = 1; break; end
            end
            if (!got) fail("b_frame_timeout");
        end
        repeat (5) tick();
        chk("b_writes", nwr_b, 8);
        chk("b_done_pulses", nfd_b, 1);
        chk("b_queue_drained", qb.size(), 0);
        chk("b_idle_busy", busy_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
